// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer
//   Read-side drain stage for a 4-bit nibble FIFO. An internal divider tick
//   paces pops. Two consecutive nibbles are packed into one byte, which is
//   presented on a valid/ready output. A half-filled byte can be flushed out
//   padded with FILL. Accepted bytes are counted modulo 256.
//
//   Optional build macro: PACKER_PARITY_EN (even parity on out_par).
//
// Ports
//   clk         single clock, all state on posedge
//   rst         synchronous reset, active-high
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO read data, sampled on the edge that ends the pop cycle
//   fifo_rd_en  one-cycle pop strobe to the FIFO (registered)
//   flush       pulse: emit a pending half byte padded with FILL
//   out_data    packed byte
//   out_valid   out_data valid
//   out_ready   consumer accepts when out_valid && out_ready
//   byte_cnt    bytes accepted by the consumer, wraps 255 -> 0
//   out_par     even parity of out_data while valid, else 0
module fifo_nibble_packer #(
  parameter int unsigned      NIB_W    = 4,
  parameter int unsigned      RD_DIV   = 2,
  parameter logic [NIB_W-1:0] FILL     = '0,
  parameter bit               LO_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [NIB_W-1:0]   fifo_rdata,
  output logic               fifo_rd_en,
  input  logic               flush,
  output logic [2*NIB_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         byte_cnt,
  output logic               out_par
);

  localparam int unsigned DIV_W = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               pend;
  logic               capture;
  logic               pop_req;
  logic               load_pair;
  logic               load_flush;
  logic               accept;
  logic [NIB_W-1:0]   lo;
  logic [2*NIB_W-1:0] byte_nx;

  assign tick = (div_cnt == DIV_W'(RD_DIV - 1));

  // The single outstanding pop always completes on the edge that ends its
  // strobe cycle, so the strobe register itself marks the pop as pending.
  assign pend = fifo_rd_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LO;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_LO:    if (capture) state_nx = S_HI;
      S_HI:    if (capture || load_flush) state_nx = S_OUT;
      S_OUT:   if (accept) state_nx = S_LO;
      default: state_nx = S_LO;
    endcase
  end

  // Control strobes and next byte value
  always_comb begin
    capture    = pend;
    accept     = out_valid && out_ready;
    pop_req    = tick && !fifo_empty && !pend && !flush &&
                 ((state == S_LO) || (state == S_HI));
    load_pair  = (state == S_HI) && capture;
    // A flush arriving while a pop is in flight is dropped; the capture wins.
    load_flush = (state == S_HI) && flush && !pend;
    byte_nx    = LO_FIRST ? {fifo_rdata, lo} : {lo, fifo_rdata};
    if (load_flush) begin
      byte_nx = LO_FIRST ? {FILL, lo} : {lo, FILL};
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      fifo_rd_en <= 1'b0;
      lo         <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);
      fifo_rd_en <= pop_req;
      if ((state == S_LO) && capture) begin
        lo <= fifo_rdata;
      end
      if (load_pair || load_flush) begin
        out_data  <= byte_nx;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
        byte_cnt  <= byte_cnt + 8'd1;
      end
    end
  end

`ifdef PACKER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par <= 1'b0;
    end else if (load_pair || load_flush) begin
      out_par <= ^byte_nx;
    end else if (accept) begin
      out_par <= 1'b0;
    end
  end
`else
  assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Testbench for fifo_nibble_packer: u_dut0 uses RD_DIV=2, u_dut1 uses RD_DIV=1.
// Each instance drains a show-ahead FIFO model held in a bench array.
module tb_fifo_nibble_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- DUT0 (RD_DIV=2) ----------------
  logic       rst0, empty0, rd0, flush0, valid0, ready0, par0;
  logic [3:0] rdata0;
  logic [7:0] data0, cnt0;
  logic [3:0] mem0 [0:1023];
  int         wp0 = 0;
  int         rp0 = 0;
  assign empty0 = (wp0 == rp0);
  assign rdata0 = mem0[rp0[9:0]];

  fifo_nibble_packer #(.NIB_W(4), .RD_DIV(2), .FILL(4'h0), .LO_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst0), .fifo_empty(empty0), .fifo_rdata(rdata0),
    .fifo_rd_en(rd0), .flush(flush0), .out_data(data0), .out_valid(valid0),
    .out_ready(ready0), .byte_cnt(cnt0), .out_par(par0)
  );

  // ---------------- DUT1 (RD_DIV=1) ----------------
  logic       rst1, empty1, rd1, flush1, valid1, ready1, par1;
  logic [3:0] rdata1;
  logic [7:0] data1, cnt1;
  logic [3:0] mem1 [0:1023];
  int         wp1 = 0;
  int         rp1 = 0;
  assign empty1 = (wp1 == rp1);
  assign rdata1 = mem1[rp1[9:0]];

  fifo_nibble_packer #(.NIB_W(4), .RD_DIV(1), .FILL(4'h0), .LO_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst(rst1), .fifo_empty(empty1), .fifo_rdata(rdata1),
    .fifo_rd_en(rd1), .flush(flush1), .out_data(data1), .out_valid(valid1),
    .out_ready(ready1), .byte_cnt(cnt1), .out_par(par1)
  );

  // FIFO pop side and pop-timing monitor
  int   cyc       = 0;
  int   last_pop0 = -100;
  int   prev_pop0 = -100;
  int   last_pop1 = -100;
  int   min_gap1  = 1000;
  logic pop_empty_err = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0) begin
      rp0       <= rp0 + 1;
      last_pop0 <= cyc;
      prev_pop0 <= last_pop0;
      if (empty0) pop_empty_err <= 1'b1;
    end
    if (rd1) begin
      rp1       <= rp1 + 1;
      last_pop1 <= cyc;
      if ((cyc - last_pop1) < min_gap1) min_gap1 <= cyc - last_pop1;
      if (empty1) pop_empty_err <= 1'b1;
    end
  end

  function automatic logic exp_par(input logic [7:0] b);
`ifdef PACKER_PARITY_EN
    return ^b;
`else
    return (b != b);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push0(input logic [3:0] n);
    mem0[wp0[9:0]] = n;
    wp0 = wp0 + 1;
  endtask

  task automatic push1(input logic [3:0] n);
    mem1[wp1[9:0]] = n;
    wp1 = wp1 + 1;
  endtask

  task automatic wait_valid(input int which, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ((which == 0) ? valid0 : valid1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: out_valid timeout", name);
    end
  endtask

  task automatic wait_pop0(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: fifo_rd_en timeout", name);
    end
  endtask

  typedef struct {
    logic [3:0] first;
    logic [3:0] second;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs [6];
  int   exp_cnt0;
  bit   ok;

  initial begin
    vecs[0] = '{4'hF, 4'h0, 8'h0F};
    vecs[1] = '{4'h1, 4'hE, 8'hE1};
    vecs[2] = '{4'hC, 4'hC, 8'hCC};
    vecs[3] = '{4'h0, 4'h0, 8'h00};
    vecs[4] = '{4'h7, 4'h8, 8'h87};
    vecs[5] = '{4'h5, 4'hA, 8'hA5};

    rst0 = 1'b1; rst1 = 1'b1;
    flush0 = 1'b0; flush1 = 1'b0;
    ready0 = 1'b1; ready1 = 1'b1;
    exp_cnt0 = 0;

    // Reset state
    step(2);
    chk("rst_data", data0, 8'h00);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_rd_en", rd0, 1'b0);
    chk("rst_cnt", cnt0, 8'h00);
    chk("rst_par", par0, 1'b0);
    chk("rst_valid1", valid1, 1'b0);
    rst0 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("idle_no_pop", rd0, 1'b0);
    end

    // Basic pack: A then 3
    push0(4'hA); push0(4'h3);
    wait_valid(0, "pack", ok);
    chk("pack_data", data0, 8'h3A);
    chk("pack_latency", cyc - last_pop0, 1);
    chk("pack_pop_gap", last_pop0 - prev_pop0, 2);
    chk("pack_par", par0, exp_par(8'h3A));
    step(1);
    exp_cnt0++;
    chk("pack_valid_1cyc", valid0, 1'b0);
    chk("pack_cnt", cnt0, exp_cnt0);

    // Table-driven packing
    foreach (vecs[k]) begin
      push0(vecs[k].first); push0(vecs[k].second);
      wait_valid(0, "tbl", ok);
      chk("tbl_data", data0, vecs[k].exp_byte);
      chk("tbl_par", par0, exp_par(vecs[k].exp_byte));
      step(1);
      exp_cnt0++;
      chk("tbl_cnt", cnt0, exp_cnt0);
    end

    // Backpressure
    ready0 = 1'b0;
    push0(4'hA); push0(4'h3); push0(4'h1); push0(4'h2);
    wait_valid(0, "bp", ok);
    chk("bp_data", data0, 8'h3A);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("bp_hold_valid", valid0, 1'b1);
      chk("bp_hold_data", data0, 8'h3A);
      chk("bp_no_pop", rd0, 1'b0);
    end
    ready0 = 1'b1;
    step(1);
    exp_cnt0++;
    chk("bp_release_cnt", cnt0, exp_cnt0);
    wait_valid(0, "bp_next", ok);
    chk("bp_next_data", data0, 8'h21);
    chk("bp_cnt_once", cnt0, exp_cnt0);
    step(1);
    exp_cnt0++;

    // Flush in S_LO is ignored
    flush0 = 1'b1; step(1); flush0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("flush_lo_ignored", valid0, 1'b0);
    end

    // Flush a half byte in S_HI
    push0(4'h5);
    step(6);
    chk("half_no_valid", valid0, 1'b0);
    flush0 = 1'b1; step(1); flush0 = 1'b0;
    chk("flush_valid", valid0, 1'b1);
    chk("flush_data", data0, 8'h05);
    chk("flush_par", par0, exp_par(8'h05));
    step(1);
    exp_cnt0++;
    chk("flush_cnt", cnt0, exp_cnt0);

    // Flush while a pop is in flight: capture wins, flush is dropped
    push0(4'h9);
    step(6);
    push0(4'h4);
    wait_pop0("flush_pend", ok);
    flush0 = 1'b1; step(1); flush0 = 1'b0;
    chk("flush_pend_valid", valid0, 1'b1);
    chk("flush_pend_data", data0, 8'h49);
    step(1);
    exp_cnt0++;
    step(4);
    chk("flush_pend_not_kept", valid0, 1'b0);

    // Mid-operation reset with a pop in flight
    push0(4'h6);
    wait_pop0("midrst", ok);
    rst0 = 1'b1; step(1); rst0 = 1'b0;
    chk("midrst_valid", valid0, 1'b0);
    chk("midrst_rd_en", rd0, 1'b0);
    chk("midrst_cnt", cnt0, 8'h00);
    chk("midrst_fifo_advanced", rp0, wp0);
    push0(4'h7); push0(4'h0);
    wait_valid(0, "midrst_byte", ok);
    chk("midrst_byte", data0, 8'h07);
    chk("midrst_par", par0, exp_par(8'h07));
    step(1);

    // Wrap with RD_DIV=1: 256 bytes
    for (int i = 0; i < 512; i++) begin
      logic [31:0] v;
      v = (i * 7 + 3);
      push1(v[3:0]);
    end
    for (int j = 0; j < 256; j++) begin
      logic [31:0] lo_v, hi_v;
      lo_v = (2 * j) * 7 + 3;
      hi_v = (2 * j + 1) * 7 + 3;
      wait_valid(1, "wrap", ok);
      if (!ok) break;
      chk("wrap_data", data1, {hi_v[3:0], lo_v[3:0]});
      if (j == 255) chk("wrap_cnt_pre", cnt1, 8'd255);
      step(1);
    end
    chk("wrap_cnt_zero", cnt1, 8'h00);
    chk("wrap_min_pop_gap", min_gap1, 2);
    chk("wrap_drained", rp1, wp1);

    chk("no_pop_when_empty", pop_empty_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
